// File: rtl/negate_ctrl.sv
// negate_ctrl: round-robin sequencer for one shared combinational 4-bit
// negate unit. Two requesters post operands; the granted operand is driven
// to the negate unit, and the registered result is presented with a
// valid/ack handshake, tagged with the owning requester.
//
// Build option: define NEGATE_CTRL_OVF_EN to register res_ovf (operand was
// 4'b1000). Without it res_ovf is constant 0.
module negate_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] a0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [3:0] a1,
  output logic       gnt1,
  output logic [3:0] neg_a,
  input  logic [3:0] neg_in,
  output logic [3:0] res,
  output logic       res_id,
  output logic       res_ovf,
  output logic       res_valid,
  input  logic       res_ack,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] op;
  logic       last;
  logic       grant;
  logic       grant_id;
  logic       load_res;
  logic       clr_valid;

  // Next-state, arbitration and datapath enables
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_id   = 1'b0;
    load_res   = 1'b0;
    clr_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant = 1'b1;
          // On a tie the requester that did not win last time is served.
          grant_id   = (req0 && req1) ? ~last : req1;
          state_next = CALC;
        end
      end
      CALC: begin
        load_res   = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (res_ack) begin
          clr_valid  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, owner tag and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op     <= '0;
      res_id <= 1'b0;
      last   <= 1'b1;
    end else if (grant) begin
      op     <= grant_id ? a1 : a0;
      res_id <= grant_id;
      last   <= grant_id;
    end
  end

  // One-cycle grant pulses following the capture edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
    end else begin
      gnt0 <= grant && !grant_id;
      gnt1 <= grant && grant_id;
    end
  end

  // Result register and valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res       <= '0;
      res_valid <= 1'b0;
    end else if (load_res) begin
      res       <= neg_in;
      res_valid <= 1'b1;
    end else if (clr_valid) begin
      res_valid <= 1'b0;
    end
  end

`ifdef NEGATE_CTRL_OVF_EN
  // Overflow flag: the most negative operand has no positive counterpart
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_ovf <= 1'b0;
    end else if (load_res) begin
      res_ovf <= (op == 4'b1000);
    end
  end
`else
  assign res_ovf = 1'b0;
`endif

  assign neg_a = op;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_negate_ctrl.sv
// Testbench for negate_ctrl: directed scenarios followed by randomized
// requester/consumer traffic, checked by a transaction-level reference
// model and a scoreboard monitor.
module tb_negate_ctrl;

`ifdef NEGATE_CTRL_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [3:0] a0 = '0;
  logic [3:0] a1 = '0;
  logic       res_ack = 1'b1;
  logic       gnt0, gnt1, res_id, res_ovf, res_valid, busy;
  logic [3:0] neg_a, neg_in, res;

  int errors = 0;
  int checks = 0;

  negate_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .a0       (a0),
    .gnt0     (gnt0),
    .req1     (req1),
    .a1       (a1),
    .gnt1     (gnt1),
    .neg_a    (neg_a),
    .neg_in   (neg_in),
    .res      (res),
    .res_id   (res_id),
    .res_ovf  (res_ovf),
    .res_valid(res_valid),
    .res_ack  (res_ack),
    .busy     (busy)
  );

  // The shared negate unit: plain two's-complement negation mod 16
  assign neg_in = 4'(5'd16 - {1'b0, neg_a});

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit       id;
    bit [3:0] r;
    bit       ovf;
  } res_t;

  res_t     sb[$];
  bit       m_pend;   // an operation is in flight (granted, not yet acked)
  bit       m_calc;   // result not yet loaded
  bit       m_last;
  bit       e_g0, e_g1;
  bit [3:0] m_op;
  bit       m_id;
  bit [3:0] m_x;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 0; m_calc = 0; m_last = 1; e_g0 = 0; e_g1 = 0; m_op = '0;
      sb.delete();
    end else begin
      e_g0 = 0;
      e_g1 = 0;
      if (m_pend) begin
        if (m_calc) m_calc = 0;
        else if (res_ack) m_pend = 0;
      end else if (req0 || req1) begin
        m_id   = (req0 && req1) ? !m_last : req1;
        m_x    = m_id ? a1 : a0;
        m_last = m_id;
        m_op   = m_x;
        m_pend = 1;
        m_calc = 1;
        if (m_id) e_g1 = 1; else e_g0 = 1;
        sb.push_back('{m_id, 4'((16 - int'(m_x)) % 16), OVF_EN && (m_x == 4'd8)});
      end
    end
  end

  // ---------------- monitor ----------------
  bit   prev_v = 0;
  bit   have = 0;
  res_t cur;

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 0;
      have   = 0;
    end else begin
      check("gnt0", gnt0, e_g0);
      check("gnt1", gnt1, e_g1);
      check("busy", busy, m_pend);
      check("res_valid", res_valid, m_pend && !m_calc);
      check("neg_a", neg_a, m_op);
      if (res_valid && !prev_v) begin
        if (sb.size() == 0) begin
          have = 0;
          check("res_unexpected", 1, 0);
        end else begin
          cur  = sb.pop_front();
          have = 1;
        end
      end
      if (res_valid && have) begin
        check("res", res, cur.r);
        check("res_id", res_id, cur.id);
        check("res_ovf", res_ovf, cur.ovf);
      end
      prev_v = res_valid;
    end
  end

  // ---------------- stimulus ----------------
  bit keep0 = 0, keep1 = 0, rnd = 0, raise = 0;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (req0 && gnt0) begin
        if (keep0) a0 = 4'($urandom_range(0, 15)); else req0 = 0;
      end
      if (req1 && gnt1) begin
        if (keep1) a1 = 4'($urandom_range(0, 15)); else req1 = 0;
      end
      if (rnd) begin
        if (raise && !req0 && $urandom_range(0, 2) == 0) begin
          req0 = 1; a0 = 4'($urandom_range(0, 15));
        end
        if (raise && !req1 && $urandom_range(0, 2) == 0) begin
          req1 = 1; a1 = 4'($urandom_range(0, 15));
        end
        res_ack = ($urandom_range(0, 3) != 0);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt0"}, gnt0, 0);
    check({tag, "_gnt1"}, gnt1, 0);
    check({tag, "_res"}, res, 0);
    check({tag, "_res_id"}, res_id, 0);
    check({tag, "_res_ovf"}, res_ovf, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_neg_a"}, neg_a, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1;
    #1 check_all_zero("rst");
    cyc(2);
    #2 rst = 0;
  endtask

  initial begin
    res_ack = 1;
    cyc(3);
    check_all_zero("por");
    #2 rst = 0;

    // single request
    a0 = 4'b0011; req0 = 1;
    cyc(6);

    // tie after reset: requester 0 first
    do_reset();
    a0 = 4'b0001; a1 = 4'b0010; req0 = 1; req1 = 1;
    cyc(8);

    // round-robin with continuous requests
    keep0 = 1; keep1 = 1; req0 = 1; req1 = 1;
    cyc(13);
    keep0 = 0; keep1 = 0;
    cyc(8);

    // backpressure with requester 1 waiting
    res_ack = 0; a0 = 4'd7; req0 = 1;
    cyc(2);
    a1 = 4'd5; req1 = 1;
    cyc(6);
    res_ack = 1;
    cyc(6);

    // boundary operands
    a0 = 4'b1000; req0 = 1;
    cyc(5);
    a0 = 4'b0000; req0 = 1;
    cyc(5);

    // reset while in CALC
    a0 = 4'd6; req0 = 1;
    cyc(1);
    #2 rst = 1;
    #1 check_all_zero("mid");
    cyc(3);
    #2 rst = 0;
    req0 = 0;
    cyc(4);
    a0 = 4'd9; a1 = 4'd4; req0 = 1; req1 = 1;
    cyc(10);

    // randomized traffic
    rnd = 1; raise = 1;
    cyc(600);
    raise = 0;
    cyc(20);
    rnd = 0; res_ack = 1;
    cyc(20);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
